lb_afpm_pipe: RTL and testbench

- Parametrised, pipelined successor to the single-cycle log-based approximate significand multiplier in the Nyuzi FP multiply path.
- Generalises significand width and pipeline depth.
- Adds a per-operation exact/approximate mode, valid/ready flow control with backpressure, and a saturating approximate-operation counter for error/energy profiling.
- Output is a double-width significand product, placed for the existing downstream normalisation stage.

---
 rtl/lb_afpm_pipe_if.sv | 24 ++
 rtl/lb_afpm_pipe.sv | 128 ++++++++++++
 tb/tb_lb_afpm_pipe.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/lb_afpm_pipe_if.sv
// Operand/product handshake bundle for lb_afpm_pipe.
// slave is the multiplier side; master is the producer/consumer side.
interface lb_afpm_pipe_if #(
  parameter int SIG_WIDTH = 23
);
  logic                     in_valid;
  logic                     in_ready;
  logic                     in_mode;
  logic [SIG_WIDTH:0]       in_sig_a;
  logic [SIG_WIDTH:0]       in_sig_b;
  logic                     out_valid;
  logic                     out_ready;
  logic [2*SIG_WIDTH+1:0]   out_product;

  modport slave (
    input  in_valid, in_mode, in_sig_a, in_sig_b, out_ready,
    output in_ready, out_valid, out_product
  );

  modport master (
    output in_valid, in_mode, in_sig_a, in_sig_b, out_ready,
    input  in_ready, out_valid, out_product
  );
endinterface

// File: rtl/lb_afpm_pipe.sv
// Elastic pipelined log-approximate / exact significand multiplier with approx-op counter.
// Define AFPM_ZERO_DETECT_EN to force a zero product when either full significand is zero.
module lb_afpm_pipe #(
  parameter int SIG_WIDTH = 23,
  parameter int STAGES    = 2,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  lb_afpm_pipe_if.slave        bus,
  input  logic                 count_clear,
  output logic [CNT_WIDTH-1:0] approx_count
);
  localparam int W  = SIG_WIDTH;
  localparam int PW = 2 * W + 2;

  logic          ma, mb, cin, h;
  logic [W:0]    la, lb, s;
  logic [W-1:0]  frac;
  logic [PW-1:0] approx_prod, exact_prod, stage_in;

  logic [STAGES-1:0]         valid_q, valid_d, load, adv;
  logic [STAGES-1:0][PW-1:0] data_q, data_d;
  logic [CNT_WIDTH-1:0]      count_q, count_d;
  logic                      take;

  // Stage-1 arithmetic: both results are formed and the mode picks one.
  always_comb begin
    ma          = bus.in_sig_a[W-1];
    mb          = bus.in_sig_b[W-1];
    la          = ma ? {2'b11, bus.in_sig_a[W-1:1]} : {1'b0, bus.in_sig_a[W-1:0]};
    lb          = mb ? {2'b11, bus.in_sig_b[W-1:1]} : {1'b0, bus.in_sig_b[W-1:0]};
    s           = la + lb;
    frac        = s[W] ? {s[W-2:0], 1'b0} : s[W-1:0];
    cin         = (ma & mb) | ((ma | mb) & ~s[W]);
    h           = bus.in_sig_a[W] & bus.in_sig_b[W];
    approx_prod = cin ? {h, frac, {(W+1){1'b0}}} : {1'b0, h, frac, {W{1'b0}}};
    exact_prod  = {{(W+1){1'b0}}, bus.in_sig_a} * {{(W+1){1'b0}}, bus.in_sig_b};
    stage_in    = bus.in_mode ? exact_prod : approx_prod;
  end

  // A stage advances when the stage after it (or the consumer) will take its data.
  always_comb begin
    adv  = '0;
    load = '0;
    take = bus.out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv[k]  = valid_q[k] & take;
      load[k] = ~valid_q[k] | adv[k];
      take    = load[k];
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load[0]) begin
      valid_d[0] = bus.in_valid;
      if (bus.in_valid) begin
        data_d[0] = stage_in;
      end
    end
    for (int k = 1; k < STAGES; k++) begin
      if (load[k]) begin
        valid_d[k] = valid_q[k-1];
        if (valid_q[k-1]) begin
          data_d[k] = data_q[k-1];
        end
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (count_clear) begin
      count_d = '0;
    end else if (bus.in_valid && load[0] && !bus.in_mode && (count_q != '1)) begin
      count_d = count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

`ifdef AFPM_ZERO_DETECT_EN
  logic              zero_in;
  logic [STAGES-1:0] zero_q, zero_d;

  // The zero flag travels alongside its product and masks it on the way out.
  always_comb begin
    zero_in = (bus.in_sig_a == '0) || (bus.in_sig_b == '0);
    zero_d  = zero_q;
    if (load[0] && bus.in_valid) begin
      zero_d[0] = zero_in;
    end
    for (int k = 1; k < STAGES; k++) begin
      if (load[k] && valid_q[k-1]) begin
        zero_d[k] = zero_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      zero_q <= '0;
    end else begin
      zero_q <= zero_d;
    end
  end

  assign bus.out_product = zero_q[STAGES-1] ? '0 : data_q[STAGES-1];
`else
  assign bus.out_product = data_q[STAGES-1];
`endif

  assign bus.in_ready  = load[0];
  assign bus.out_valid = valid_q[STAGES-1];
  assign approx_count  = count_q;
endmodule

// File: tb/tb_lb_afpm_pipe.sv
// Self-checking bench for lb_afpm_pipe: fixed vectors, stall/reset/counter sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_lb_afpm_pipe;
  localparam int W  = 23;
  localparam int S  = 2;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          count_clear;
  logic [CW-1:0] approx_count;

  lb_afpm_pipe_if #(.SIG_WIDTH(W)) bus ();

  lb_afpm_pipe #(.SIG_WIDTH(W), .STAGES(S), .CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .count_clear  (count_clear),
    .approx_count (approx_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mode;
    logic [W:0]  a;
    logic [W:0]  b;
    logic [47:0] exp;
  } vec_t;

  int              checks = 0;
  int              errors = 0;
  longint          edge_n = 0;
  logic [47:0]     q_prod[$];
  longint          q_acc[$];
  longint          last_leave = 0;
  int              cnt_m = 0;
  int              n_out = 0;
  logic [47:0]     last_out = '0;
  logic            stall_prev = 1'b0;
  logic [47:0]     held = '0;
  logic            last_in_ready = 1'b1;

  always @(posedge clk) edge_n <= edge_n + 1;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference product computed from the arithmetic rules with plain integers.
  function automatic logic [47:0] model(input logic mode, input logic [W:0] a, input logic [W:0] b);
    longint unsigned fa, fb, ma, mb, la, lb, s, sc, frac, cin, h;
`ifdef AFPM_ZERO_DETECT_EN
    if (a == 0 || b == 0) return 48'd0;
`endif
    if (mode) return 48'(longint'(a) * longint'(b));
    fa   = longint'(a) % (64'd1 << W);
    fb   = longint'(b) % (64'd1 << W);
    ma   = fa >> (W - 1);
    mb   = fb >> (W - 1);
    la   = (ma != 0) ? 3 * (64'd1 << (W - 1)) + fa / 2 : fa;
    lb   = (mb != 0) ? 3 * (64'd1 << (W - 1)) + fb / 2 : fb;
    s    = (la + lb) % (64'd1 << (W + 1));
    sc   = s >> W;
    frac = (sc != 0) ? (2 * s) % (64'd1 << W) : s % (64'd1 << W);
    cin  = ((ma != 0 && mb != 0) || ((ma != 0 || mb != 0) && sc == 0)) ? 1 : 0;
    h    = (longint'(a) >> W) & (longint'(b) >> W);
    if (cin != 0) return 48'(h * (64'd1 << (2 * W + 1)) + frac * (64'd1 << (W + 1)));
    return 48'(h * (64'd1 << (2 * W)) + frac * (64'd1 << W));
  endfunction

  // One cycle: settle, compare against the model, update it, advance to the next negedge.
  task automatic step();
    logic   exp_valid;
    longint hr;
    #1;
    exp_valid = 1'b0;
    if (q_prod.size() > 0) begin
      hr = q_acc[0] + S - 1;
      if (last_leave > hr) hr = last_leave;
      exp_valid = (edge_n >= hr);
    end
    chk("out_valid", 64'(bus.out_valid), 64'(exp_valid));
    chk("in_ready", 64'(bus.in_ready), 64'((q_prod.size() < S) || bus.out_ready));
    chk("approx_count", 64'(approx_count), 64'(cnt_m));
    if (stall_prev) chk("hold", 64'(bus.out_product), 64'(held));
    if (bus.out_valid && bus.out_ready && q_prod.size() > 0) begin
      chk("out_product", 64'(bus.out_product), 64'(q_prod[0]));
      last_out = bus.out_product;
      void'(q_prod.pop_front());
      void'(q_acc.pop_front());
      last_leave = edge_n + 1;
      n_out++;
    end
    stall_prev    = bus.out_valid && !bus.out_ready;
    held          = bus.out_product;
    last_in_ready = bus.in_ready;
    if (bus.in_valid && bus.in_ready) begin
      q_prod.push_back(model(bus.in_mode, bus.in_sig_a, bus.in_sig_b));
      q_acc.push_back(edge_n + 1);
    end
    if (count_clear) cnt_m = 0;
    else if (bus.in_valid && bus.in_ready && !bus.in_mode && cnt_m < (1 << CW) - 1) cnt_m++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_product", 64'(bus.out_product), 64'd0);
    chk("rst_count", 64'(approx_count), 64'd0);
    q_prod.delete();
    q_acc.delete();
    cnt_m      = 0;
    stall_prev = 1'b0;
    last_leave = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drive(input logic v, input logic m, input logic [W:0] a, input logic [W:0] b);
    bus.in_valid = v;
    bus.in_mode  = m;
    bus.in_sig_a = a;
    bus.in_sig_b = b;
  endtask

  initial begin
    vec_t vt[7];
    int   n0;
    int   base;
    logic saw_low;

    vt[0] = '{1'b0, 24'h800000, 24'h800000, 48'h400000000000};
    vt[1] = '{1'b0, 24'hC00000, 24'hC00000, 48'h800000000000};
    vt[2] = '{1'b1, 24'hC00000, 24'hC00000, 48'h900000000000};
    vt[3] = '{1'b0, 24'hC00000, 24'h800000, 48'h600000000000};
    vt[4] = '{1'b0, 24'h000000, 24'h800000, 48'h000000000000};
    vt[5] = '{1'b1, 24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001};
    vt[6] = '{1'b1, 24'h000000, 24'h123456, 48'h000000000000};

    reset         = 1'b1;
    count_clear   = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    do_reset();

    // Fixed vectors, one at a time.
    for (int i = 0; i < 7; i++) begin
      n0 = n_out;
      drive(1'b1, vt[i].mode, vt[i].a, vt[i].b);
      step();
      drive(1'b0, 1'b0, '0, '0);
      for (int t = 0; t < 10 && n_out == n0; t++) step();
      chk($sformatf("vec%0d_done", i), 64'(n_out), 64'(n0 + 1));
      if (n_out == n0 + 1) chk($sformatf("vec%0d", i), 64'(last_out), 64'(vt[i].exp));
      if (i == 0) chk("vec0_count", 64'(approx_count), 64'd1);
    end

    // Stream of 8 with the consumer stalled for cycles 3..6.
    base    = n_out;
    saw_low = 1'b0;
    for (int c = 0, sent = 0; c < 30; c++) begin
      drive(sent < 8, c[0], 24'($urandom), 24'($urandom));
      bus.out_ready = !(c >= 3 && c <= 6);
      step();
      if (!last_in_ready) saw_low = 1'b1;
      else if (bus.in_valid) sent++;
    end
    bus.out_ready = 1'b1;
    drive(1'b0, 1'b0, '0, '0);
    chk("stream_count", 64'(n_out - base), 64'd8);
    chk("stream_backpressure", 64'(saw_low), 64'd1);

    // Counter: clear wins over a same-cycle approximate accept, then saturation.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 24'($urandom), 24'($urandom));
      step();
    end
    count_clear = 1'b1;
    step();
    count_clear = 1'b0;
    chk("clear_priority", 64'(approx_count), 64'd0);
    for (int i = 0; i < 17; i++) step();
    drive(1'b0, 1'b0, '0, '0);
    step();
    chk("saturate", 64'(approx_count), 64'd15);
    for (int i = 0; i < 4; i++) step();

    // Reset with two operations in flight.
    bus.out_ready = 1'b0;
    drive(1'b1, 1'b0, 24'hC00000, 24'h800000);
    step();
    drive(1'b1, 1'b1, 24'h9ABCDE, 24'h876543);
    step();
    drive(1'b0, 1'b0, '0, '0);
    chk("pre_reset_valid", 64'(bus.out_valid), 64'd1);
    do_reset();
    bus.out_ready = 1'b1;
    n0 = n_out;
    for (int i = 0; i < 6; i++) step();
    chk("no_stale", 64'(n_out), 64'(n0));

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(3) != 0), 1'($urandom),
            ($urandom_range(7) == 0) ? 24'd0 : 24'($urandom),
            ($urandom_range(7) == 0) ? 24'd0 : 24'($urandom));
      bus.out_ready = ($urandom_range(3) != 0);
      count_clear   = ($urandom_range(31) == 0);
      step();
    end
    drive(1'b0, 1'b0, '0, '0);
    count_clear   = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    chk("drained", 64'(q_prod.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
